// File: rtl/bcd_display_scan_pkg.sv
// Shared constants for the four-digit BCD scan display: active-low
// segment patterns {g,f,e,d,c,b,a} and the scan FSM state encoding.
package bcd_display_scan_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  typedef enum logic {
    ST_GAP   = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_display_scan_dec.sv
// Combinational BCD to active-low 7-segment decode; codes above 9 show a dash.
module bcd_to_seg
  import bcd_display_scan_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Four-digit multiplexed display scanner: shadowed BCD digits, per-slot blanking gap,
// optional leading-zero blanking. Seg/An are registered from next-state so they line up with the counter.
module bcd_display_scan
  import bcd_display_scan_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int GAP_CYC  = 500
) (
  input  logic       Clock,
  input  logic       Clear,
  input  logic       Load,
  input  logic [3:0] BCD3,
  input  logic [3:0] BCD2,
  input  logic [3:0] BCD1,
  input  logic [3:0] BCD0,
  input  logic       Blank_En,
  output logic [6:0] Seg,
  output logic [3:0] An,
  output logic [1:0] Digit_Sel,
  output logic       Slot_Tick
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  state_t        state_q, state_d;
  logic [3:0]    dig_q [4];
  logic [3:0]    dig_d [4];
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          tick_q;
  logic          wrap;
  logic [3:0]    blank;
  logic [3:0]    cur_dig;
  logic [6:0]    dec_seg;

  assign wrap = (cnt_q == CW'(SCAN_DIV - 1));

  always_comb begin
    for (int k = 0; k < 4; k++) dig_d[k] = dig_q[k];
    if (Load) begin
      dig_d[3] = BCD3;
      dig_d[2] = BCD2;
      dig_d[1] = BCD1;
      dig_d[0] = BCD0;
    end
  end

  // Blanking looks at the next shadow value so a Load is visible on the very next cycle.
  always_comb begin
    blank    = 4'b0000;
    blank[3] = Blank_En && (dig_d[3] == 4'd0);
    blank[2] = blank[3] && (dig_d[2] == 4'd0);
    blank[1] = blank[2] && (dig_d[1] == 4'd0);
  end

  assign cur_dig = dig_d[sel_d];

  bcd_to_seg u_dec (
    .bcd_i (cur_dig),
    .seg_o (dec_seg)
  );

  always_comb begin
    cnt_d   = wrap ? '0 : cnt_q + CW'(1);
    sel_d   = wrap ? sel_q + 2'd1 : sel_q;
    state_d = state_q;
    case (state_q)
      ST_GAP:   if (cnt_d == CW'(GAP_CYC)) state_d = ST_DRIVE;
      ST_DRIVE: if (wrap) state_d = ST_GAP;
      default:  state_d = ST_GAP;
    endcase
    an_d  = 4'b1111;
    seg_d = SEG_OFF;
    if (state_d == ST_DRIVE) begin
      an_d = ~(4'b0001 << sel_d);
      if (!blank[sel_d]) seg_d = dec_seg;
    end
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      cnt_q   <= '0;
      sel_q   <= 2'd0;
      state_q <= ST_GAP;
      for (int k = 0; k < 4; k++) dig_q[k] <= 4'd0;
      seg_q   <= SEG_OFF;
      an_q    <= 4'b1111;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      state_q <= state_d;
      for (int k = 0; k < 4; k++) dig_q[k] <= dig_d[k];
      seg_q   <= seg_d;
      an_q    <= an_d;
      tick_q  <= (cnt_d == '0);
    end
  end

  assign Seg       = seg_q;
  assign An        = an_q;
  assign Digit_Sel = sel_q;
  assign Slot_Tick = tick_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan (SCAN_DIV=8, GAP_CYC=2): directed scenarios then random
// loads/clears, every cycle compared against a time-indexed reference model.
module tb_bcd_display_scan;

  localparam int DIV = 8;
  localparam int GAP = 2;

  logic       Clock = 1'b0;
  logic       Clear = 1'b1;
  logic       Load = 1'b0;
  logic [3:0] BCD3 = 4'd0, BCD2 = 4'd0, BCD1 = 4'd0, BCD0 = 4'd0;
  logic       Blank_En = 1'b0;
  logic [6:0] Seg;
  logic [3:0] An;
  logic [1:0] Digit_Sel;
  logic       Slot_Tick;

  int checks = 0;
  int errors = 0;

  // Reference model: cycles since Clear, shadow digits, sampled Blank_En.
  int         t = 0;
  bit         started = 0;
  logic [3:0] sh [4];
  logic       be_m = 1'b0;
  logic [6:0] segtab [16];

  bcd_display_scan #(.SCAN_DIV(DIV), .GAP_CYC(GAP)) dut (
    .Clock     (Clock),
    .Clear     (Clear),
    .Load      (Load),
    .BCD3      (BCD3),
    .BCD2      (BCD2),
    .BCD1      (BCD1),
    .BCD0      (BCD0),
    .Blank_En  (Blank_En),
    .Seg       (Seg),
    .An        (An),
    .Digit_Sel (Digit_Sel),
    .Slot_Tick (Slot_Tick)
  );

  always #5 Clock = ~Clock;

  function automatic int m_slot();
    return (t / DIV) % 4;
  endfunction

  function automatic int m_pos();
    return t % DIV;
  endfunction

  function automatic logic [3:0] exp_an();
    if (m_pos() < GAP) return 4'b1111;
    return 4'(~(4'b0001 << m_slot()));
  endfunction

  function automatic logic [6:0] exp_seg();
    int  k;
    bit  lead_zero;
    k = m_slot();
    if (m_pos() < GAP) return 7'b1111111;
    lead_zero = (k > 0);
    for (int j = k; j < 4; j++) if (sh[j] != 4'd0) lead_zero = 0;
    if (be_m && lead_zero) return 7'b1111111;
    return segtab[sh[k]];
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    if (Clear) begin
      t = 0;
      started = 1;
      for (int k = 0; k < 4; k++) sh[k] = 4'd0;
    end else begin
      t++;
      if (Load) begin
        sh[3] = BCD3; sh[2] = BCD2; sh[1] = BCD1; sh[0] = BCD0;
      end
    end
    be_m = Blank_En;
    #1;
    if (started) begin
      chk("an", 7'(An), 7'(exp_an()));
      chk("seg", Seg, exp_seg());
      chk("digit_sel", 7'(Digit_Sel), 7'(m_slot()));
      chk("slot_tick", 7'(Slot_Tick), 7'((m_pos() == 0) && (t > 0)));
    end
  endtask

  task automatic load_digits(input logic [3:0] d3, d2, d1, d0);
    BCD3 = d3; BCD2 = d2; BCD1 = d1; BCD0 = d0;
    Load = 1'b1;
    step();
    Load = 1'b0;
    BCD3 = 4'($urandom_range(0, 15)); BCD2 = 4'($urandom_range(0, 15));
    BCD1 = 4'($urandom_range(0, 15)); BCD0 = 4'($urandom_range(0, 15));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_slot_pos(input int s, input int p);
    for (int i = 0; i < 4 * DIV && !(m_slot() == s && m_pos() == p); i++) step();
  endtask

  initial begin
    segtab[0] = 7'b1000000; segtab[1] = 7'b1111001; segtab[2] = 7'b0100100;
    segtab[3] = 7'b0110000; segtab[4] = 7'b0011001; segtab[5] = 7'b0010010;
    segtab[6] = 7'b0000010; segtab[7] = 7'b1111000; segtab[8] = 7'b0000000;
    segtab[9] = 7'b0010000;
    for (int c = 10; c < 16; c++) segtab[c] = 7'b0111111;

    // Reset state, then load 1,2,3,4 at the last cycle of the first slot.
    Clear = 1'b1;
    run(2);
    Clear = 1'b0;
    run(6);
    load_digits(4'd1, 4'd2, 4'd3, 4'd4);
    run(4 * DIV);

    // Leading-zero blanking on 0050, with and without enable.
    Blank_En = 1'b1;
    load_digits(4'd0, 4'd0, 4'd5, 4'd0);
    run(4 * DIV);
    Blank_En = 1'b0;
    run(4 * DIV);

    // All zeros: only digit 0 lit.
    Blank_En = 1'b1;
    load_digits(4'd0, 4'd0, 4'd0, 4'd0);
    run(4 * DIV);

    // Illegal code shows a dash.
    Blank_En = 1'b0;
    load_digits(4'd0, 4'd0, 4'd0, 4'hC);
    run(4 * DIV);

    // Load mid-slot 2 must not disturb the scan timing.
    wait_slot_pos(2, 4);
    load_digits(4'd7, 4'd6, 4'd9, 4'd8);
    run(4 * DIV);

    // Clear together with Load during DRIVE of slot 3.
    wait_slot_pos(3, 4);
    BCD3 = 4'd9; BCD2 = 4'd9; BCD1 = 4'd9; BCD0 = 4'd9;
    Load = 1'b1;
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    Load = 1'b0;
    run(4 * DIV + 2);

    // Random loads, digits biased toward zero, occasional Blank_En flips and Clears.
    for (int i = 0; i < 2000; i++) begin
      Load = ($urandom_range(0, 4) == 0);
      BCD3 = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
      BCD2 = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
      BCD1 = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
      BCD0 = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
      if ($urandom_range(0, 9) == 0) Blank_En = ~Blank_En;
      Clear = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
